spi_sd_responder: RTL and testbench

SPI_SD_RESPONDER -- requirements
Module: spi_sd_responder

---
 rtl/spi_sd_responder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_spi_sd_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sd_responder.sv
// spi_sd_responder
// SD-card style SPI responder. It receives 6-byte commands and answers with an
// R1 byte. For an accepted CMD17 it then streams a 512-byte block, fetched from
// an external word buffer, framed by a start token and two CRC bytes.
// The SPI pins are oversampled by the system clock, which must be at least
// 8x SCK.
//
// Ports
//   spi_clk_i    system clock, rising edge
//   spi_rstn_i   asynchronous active-low reset
//   SCK/SS/MOSI  SPI mode 0 inputs from the master (SS active-low)
//   MISO         response data, idle high
//   cmd_o        last complete 48-bit command frame
//   cmd_valid_o  one-cycle pulse when cmd_o updates
//   blk_addr_o   argument of the last accepted CMD17
//   rd_req_o     block-buffer read strobe
//   rd_addr_o    buffer word index 0..127
//   rd_data_i    buffer word, valid one cycle after rd_req_o
//   idle_o       card-idle flag (R1 bit 0)
//
// Configuration
//   SPI_SD_CRC_CHECK_EN  when defined, the CRC7 of each command is checked.
//                        A bad CRC answers R1 = 0x08 | idle and leaves the
//                        card state untouched.

module spi_sd_responder (
    input  logic        spi_clk_i,
    input  logic        spi_rstn_i,
    input  logic        SCK,
    input  logic        SS,
    input  logic        MOSI,
    output logic        MISO,
    output logic [47:0] cmd_o,
    output logic        cmd_valid_o,
    output logic [31:0] blk_addr_o,
    output logic        rd_req_o,
    output logic [6:0]  rd_addr_o,
    input  logic [31:0] rd_data_i,
    output logic        idle_o
);

    typedef enum logic [2:0] {IDLE, CMD, NCR, R1, GAP, TOKEN, DATA, CRC} state_t;

    state_t      state, state_next;
    logic [2:0]  sck_sync;
    logic [1:0]  ss_sync, mosi_sync;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [39:0] cmd_shift;
    logic [2:0]  cmd_cnt;
    logic [7:0]  tx_shift, tx_next;
    logic [1:0]  byte_idx;
    logic [6:0]  word_idx;
    logic [31:0] data_word;
    logic        rd_cap;
    logic [7:0]  r1_val, r1_next;
    logic        accept, accept_next;
    logic        idle, idle_next;
    logic        acmd, acmd_next;

    logic        sck_rise, sck_fall, ss_high, mosi_bit, byte_done;
    logic [7:0]  rx_byte;
    logic [47:0] frame;

    // The third SCK stage only exists for edge detection, so SCK edges line up
    // with the two-stage MOSI and SS samples.
    assign sck_rise  = sck_sync[1] & ~sck_sync[2];
    assign sck_fall  = ~sck_sync[1] & sck_sync[2];
    assign ss_high   = ss_sync[1];
    assign mosi_bit  = mosi_sync[1];
    assign rx_byte   = {rx_shift, mosi_bit};
    assign byte_done = sck_rise & ~ss_high & (bit_cnt == 3'd7);
    assign frame     = {cmd_shift, rx_byte};
    assign MISO      = tx_shift[7];
    assign idle_o    = idle;

`ifdef SPI_SD_CRC_CHECK_EN
    // CRC7, polynomial x^7 + x^3 + 1, over the first 40 frame bits.
    function automatic logic [6:0] crc7(input logic [39:0] bits);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = bits[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction
`endif

    // Command decode. This is evaluated on the frame that completes in the
    // current cycle and only takes effect at frame_done.
    always_comb begin
        r1_next     = 8'h04 | {7'b0, idle};
        accept_next = 1'b0;
        idle_next   = idle;
        acmd_next   = 1'b0;
        case (frame[45:40])
            6'd0: begin
                r1_next   = 8'h01;
                idle_next = 1'b1;
            end
            6'd55: begin
                r1_next   = {7'b0, idle};
                acmd_next = 1'b1;
            end
            6'd41: if (acmd) begin
                r1_next   = 8'h00;
                idle_next = 1'b0;
            end
            6'd17: if (!idle) begin
                r1_next     = 8'h00;
                accept_next = 1'b1;
            end
            default: ;
        endcase
`ifdef SPI_SD_CRC_CHECK_EN
        if (crc7(frame[47:8]) != frame[7:1]) begin
            r1_next     = 8'h08 | {7'b0, idle};
            accept_next = 1'b0;
            idle_next   = idle;
            acmd_next   = acmd;
        end
`endif
    end

    // Byte-level sequencing. Transitions happen only at byte boundaries, except
    // that SS high forces IDLE.
    always_comb begin
        state_next = state;
        if (ss_high) begin
            state_next = IDLE;
        end else if (byte_done) begin
            case (state)
                IDLE:    if (rx_byte[7:6] == 2'b01) state_next = CMD;
                CMD:     if (cmd_cnt == 3'd5) state_next = NCR;
                NCR:     state_next = R1;
                R1:      state_next = accept ? GAP : IDLE;
                GAP:     state_next = TOKEN;
                TOKEN:   state_next = DATA;
                DATA:    if (byte_idx == 2'd3 && word_idx == 7'd127) state_next = CRC;
                CRC:     if (byte_idx == 2'd1) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Byte to put on MISO for the byte that starts in the current state.
    always_comb begin
        tx_next = 8'hFF;
        case (state)
            R1:    tx_next = r1_val;
            TOKEN: tx_next = 8'hFE;
            DATA: begin
                case (byte_idx)
                    2'd0:    tx_next = data_word[31:24];
                    2'd1:    tx_next = data_word[23:16];
                    2'd2:    tx_next = data_word[15:8];
                    default: tx_next = data_word[7:0];
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge spi_clk_i or negedge spi_rstn_i) begin
        if (!spi_rstn_i) state <= IDLE;
        else             state <= state_next;
    end

    // A new byte is loaded on the SCK falling edge that follows a completed
    // byte, so its MSB is on MISO before the master's next rising edge. Buffer
    // reads are issued on that same edge. The word being replaced has already
    // been copied into tx_shift, and the new word is needed only a full byte
    // later.
    always_ff @(posedge spi_clk_i or negedge spi_rstn_i) begin
        if (!spi_rstn_i) begin
            sck_sync    <= '0;
            ss_sync     <= 2'b11;
            mosi_sync   <= 2'b11;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            cmd_shift   <= '0;
            cmd_cnt     <= '0;
            tx_shift    <= 8'hFF;
            byte_idx    <= '0;
            word_idx    <= '0;
            data_word   <= '0;
            rd_cap      <= 1'b0;
            r1_val      <= 8'hFF;
            accept      <= 1'b0;
            idle        <= 1'b1;
            acmd        <= 1'b0;
            cmd_o       <= '0;
            cmd_valid_o <= 1'b0;
            blk_addr_o  <= '0;
            rd_req_o    <= 1'b0;
            rd_addr_o   <= '0;
        end else begin
            sck_sync    <= {sck_sync[1:0], SCK};
            ss_sync     <= {ss_sync[0], SS};
            mosi_sync   <= {mosi_sync[0], MOSI};
            cmd_valid_o <= 1'b0;
            rd_req_o    <= 1'b0;
            rd_cap      <= rd_req_o;
            if (rd_cap) data_word <= rd_data_i;

            if (ss_high) begin
                bit_cnt  <= '0;
                tx_shift <= 8'hFF;
                cmd_cnt  <= '0;
                byte_idx <= '0;
                word_idx <= '0;
            end else begin
                if (sck_rise) begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    rx_shift <= {rx_shift[5:0], mosi_bit};
                end
                if (sck_fall) begin
                    if (bit_cnt == 3'd0) begin
                        tx_shift <= tx_next;
                        if (state == TOKEN) begin
                            rd_req_o  <= 1'b1;
                            rd_addr_o <= 7'd0;
                        end else if (state == DATA && byte_idx == 2'd3 && word_idx != 7'd127) begin
                            rd_req_o  <= 1'b1;
                            rd_addr_o <= word_idx + 7'd1;
                        end
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b1};
                    end
                end
                if (byte_done) begin
                    case (state)
                        IDLE: if (rx_byte[7:6] == 2'b01) begin
                            cmd_shift <= {32'b0, rx_byte};
                            cmd_cnt   <= 3'd1;
                        end
                        CMD: begin
                            cmd_shift <= frame[39:0];
                            cmd_cnt   <= cmd_cnt + 3'd1;
                            if (cmd_cnt == 3'd5) begin
                                cmd_o       <= frame;
                                cmd_valid_o <= 1'b1;
                                r1_val      <= r1_next;
                                accept      <= accept_next;
                                idle        <= idle_next;
                                acmd        <= acmd_next;
                                cmd_cnt     <= '0;
                                if (accept_next) blk_addr_o <= frame[39:8];
                            end
                        end
                        DATA: begin
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) word_idx <= word_idx + 7'd1;
                        end
                        CRC: byte_idx <= (byte_idx == 2'd1) ? 2'd0 : byte_idx + 2'd1;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_sd_responder.sv
module tb_spi_sd_responder;

    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        ss = 1'b1;
    logic        mosi = 1'b1;
    logic        miso;
    logic [47:0] cmd;
    logic        cmd_valid;
    logic [31:0] blk_addr;
    logic        rd_req;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data = '0;
    logic        idle;

    logic [31:0] mem [0:127];
    int          total = 0;
    int          bad = 0;
    int          valid_cnt = 0;
    int          rd_cnt = 0;
    int          addr_err = 0;
    logic        m_idle = 1'b1;
    logic        m_acmd = 1'b0;

    spi_sd_responder dut (
        .spi_clk_i   (clk),
        .spi_rstn_i  (rst_n),
        .SCK         (sck),
        .SS          (ss),
        .MOSI        (mosi),
        .MISO        (miso),
        .cmd_o       (cmd),
        .cmd_valid_o (cmd_valid),
        .blk_addr_o  (blk_addr),
        .rd_req_o    (rd_req),
        .rd_addr_o   (rd_addr),
        .rd_data_i   (rd_data),
        .idle_o      (idle)
    );

    always #5 clk = ~clk;

    // Block buffer with one cycle of read latency, plus strobe bookkeeping.
    // Reads within a block must walk 0..127, so the address is checked
    // against the running strobe count.
    always @(posedge clk) begin
        if (rd_req) begin
            rd_data <= mem[rd_addr];
            if (rd_addr !== rd_cnt[6:0]) addr_err++;
            rd_cnt++;
        end
        if (cmd_valid) valid_cnt++;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [6:0] crc7_ref(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] head;
        head = {2'b01, idx, arg};
        return {head, crc7_ref(head), 1'b1};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One SPI byte, MSB first, optionally truncated to nbits. MISO is sampled
    // on each SCK rising edge.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'hFF;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            rx[i] = miso;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    // Card behaviour: expected R1 and data-phase acceptance, updating the
    // idle flag and the ACMD arm.
    task automatic model_cmd(input logic [47:0] f, output logic [7:0] r1, output logic acc);
        logic ok;
        ok  = 1'b1;
        acc = 1'b0;
`ifdef SPI_SD_CRC_CHECK_EN
        ok = (crc7_ref(f[47:8]) == f[7:1]);
`endif
        if (!ok) begin
            r1 = 8'h08 + {7'b0, m_idle};
        end else if (f[45:40] == 6'd0) begin
            r1 = 8'h01; m_idle = 1'b1; m_acmd = 1'b0;
        end else if (f[45:40] == 6'd55) begin
            r1 = {7'b0, m_idle}; m_acmd = 1'b1;
        end else if (f[45:40] == 6'd41 && m_acmd) begin
            r1 = 8'h00; m_idle = 1'b0; m_acmd = 1'b0;
        end else if (f[45:40] == 6'd17 && !m_idle) begin
            r1 = 8'h00; acc = 1'b1; m_acmd = 1'b0;
        end else begin
            r1 = 8'h04 + {7'b0, m_idle}; m_acmd = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [47:0] f);
        logic [7:0] rx;
        for (int b = 0; b < 6; b++) begin
            xfer(f[47 - 8*b -: 8], 8, rx);
            checkOutput("miso_during_cmd", 64'(rx), 64'hFF);
        end
    endtask

    // Full command round trip: command, NCR, R1 and, if accepted, the whole
    // data phase. Random MOSI is sent during the response bytes.
    task automatic applyStimulus(input logic [47:0] f);
        logic [7:0] rx, r1;
        logic       acc;
        int         v0, rd0;
        v0  = valid_cnt;
        rd0 = rd_cnt;
        send_frame(f);
        model_cmd(f, r1, acc);
        xfer(8'($urandom_range(0, 255)), 8, rx);
        checkOutput("ncr", 64'(rx), 64'hFF);
        checkOutput("cmd_valid_pulses", 64'(valid_cnt - v0), 64'd1);
        checkOutput("cmd_o", 64'(cmd), 64'(f));
        xfer(8'($urandom_range(0, 255)), 8, rx);
        checkOutput("r1", 64'(rx), 64'(r1));
        if (acc) begin
            xfer(8'($urandom_range(0, 255)), 8, rx);
            checkOutput("gap", 64'(rx), 64'hFF);
            xfer(8'($urandom_range(0, 255)), 8, rx);
            checkOutput("token", 64'(rx), 64'hFE);
            for (int n = 0; n < 512; n++) begin
                xfer(8'($urandom_range(0, 255)), 8, rx);
                checkOutput("data", 64'(rx), 64'(8'(mem[n / 4] >> (24 - 8 * (n % 4)))));
            end
            for (int n = 0; n < 2; n++) begin
                xfer(8'($urandom_range(0, 255)), 8, rx);
                checkOutput("crc_byte", 64'(rx), 64'hFF);
            end
            checkOutput("blk_addr", 64'(blk_addr), 64'(f[39:8]));
            checkOutput("rd_addr_order", 64'(addr_err), 64'd0);
        end
        checkOutput("rd_req_count", 64'(rd_cnt - rd0), acc ? 64'd128 : 64'd0);
        checkOutput("idle_o", 64'(idle), 64'(m_idle));
    endtask

    initial begin
        logic [7:0]  rx, r1;
        logic        acc;
        logic [5:0]  idx;
        logic [31:0] addr;
        int          v0, rd0;

        repeat (5) @(negedge clk);
        checkOutput("reset_miso", 64'(miso), 64'd1);
        checkOutput("reset_cmd", 64'(cmd), 64'd0);
        checkOutput("reset_cmd_valid", 64'(cmd_valid), 64'd0);
        checkOutput("reset_blk_addr", 64'(blk_addr), 64'd0);
        checkOutput("reset_rd_req", 64'(rd_req), 64'd0);
        checkOutput("reset_rd_addr", 64'(rd_addr), 64'd0);
        checkOutput("reset_idle", 64'(idle), 64'd1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        ss = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] init sequence");
        applyStimulus(48'h40_00_00_00_00_95);
        applyStimulus(48'h51_00_00_02_00_55);
        applyStimulus(48'h77_00_00_00_00_65);
        applyStimulus(48'h69_40_00_00_00_77);
        applyStimulus(make_frame(6'd9, 32'd0));
        for (int k = 0; k < 3; k++) begin
            do idx = 6'($urandom_range(0, 63));
            while (idx == 6'd0 || idx == 6'd17 || idx == 6'd41 || idx == 6'd55);
            applyStimulus(make_frame(idx, $urandom));
        end
        applyStimulus(48'h77_00_00_00_00_65);
        applyStimulus(make_frame(6'd9, 32'd0));
        applyStimulus(48'h69_40_00_00_00_77);

        $display("[TB] block read");
        for (int k = 0; k < 128; k++) mem[k] = 32'hA0B0C000 + k;
        applyStimulus(48'h51_00_00_02_00_55);

        $display("[TB] partial frame abort");
        xfer(8'h77, 8, rx);
        xfer(8'h00, 8, rx);
        xfer(8'h00, 8, rx);
        ss = 1'b1;
        repeat (20) @(negedge clk);
        ss = 1'b0;
        repeat (10) @(negedge clk);
        applyStimulus(48'h77_00_00_00_00_65);

        $display("[TB] abort during data");
        for (int k = 0; k < 128; k++) mem[k] = $urandom;
        mem[25][28] = 1'b0;
        addr = $urandom;
        v0   = valid_cnt;
        rd0  = rd_cnt;
        send_frame(make_frame(6'd17, addr));
        model_cmd(make_frame(6'd17, addr), r1, acc);
        xfer(8'hFF, 8, rx);
        xfer(8'hFF, 8, rx);
        checkOutput("abort_r1", 64'(rx), 64'(r1));
        xfer(8'hFF, 8, rx);
        xfer(8'hFF, 8, rx);
        checkOutput("abort_token", 64'(rx), 64'hFE);
        for (int n = 0; n < 100; n++) begin
            xfer(8'($urandom_range(0, 255)), 8, rx);
            checkOutput("abort_data", 64'(rx), 64'(8'(mem[n / 4] >> (24 - 8 * (n % 4)))));
        end
        xfer(8'hFF, 4, rx);
        checkOutput("abort_pre_miso", 64'(rx[4]), 64'd0);
        ss = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("abort_miso_high", 64'(miso), 64'd1);
        checkOutput("abort_rd_count", 64'(rd_cnt - rd0), 64'd26);
        checkOutput("abort_blk_addr", 64'(blk_addr), 64'(addr));
        checkOutput("abort_idle_kept", 64'(idle), 64'(m_idle));
        checkOutput("abort_valid", 64'(valid_cnt - v0), 64'd1);
        repeat (20) @(negedge clk);
        ss = 1'b0;
        repeat (10) @(negedge clk);
        applyStimulus(48'h40_00_00_00_00_95);

`ifdef SPI_SD_CRC_CHECK_EN
        $display("[TB] crc check");
        applyStimulus(48'h40_00_00_00_00_00);
        applyStimulus(48'h40_00_00_00_00_95);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
